dual_port_stack_ram: RTL
========================

// Module: dual_port_stack_ram
// PURPOSE
//  Parametrised synchronous dual-port RAM for the stack processor; generalises the 1Kx16 single-port block memory.
//  Port A: read-only instruction-fetch port. Port B: read/write data port with byte enables.
//  Configurable read latency (1 or 2 cycles) and collision mode. Optional zero-clear sweep after reset.
//  Sits between the datapath (PC / memory-address regs) and the inferred block RAM.
// PARAMETERS
//  DATA_W      16  word width in bits; must be a multiple of 8
//  ADDR_W      10  address width; DEPTH = 2**ADDR_W words
//  OUT_REG     0   0: read latency 1 cycle; 1: extra output register, latency 2
//  WRITE_MODE  0   0: read-first (A sees old data on collision); 1: write-first (A sees new data)
//  CLEAR_INIT  1   1: zero every word after reset before accepting requests; 0: no sweep
// PORTS
//  clka     in   1          clock, all activity on rising edge
//  rst_n    in   1          synchronous reset, active-low
//  ready    out  1          high when requests are accepted (low during clear sweep)
//  a_req    in   1          port-A read request
//  a_addr   in   ADDR_W     port-A word address
//  a_rdata  out  DATA_W     port-A read data
//  a_valid  out  1          one-cycle pulse: a_rdata valid
//  b_req    in   1          port-B request
//  b_we     in   1          1 = write, 0 = read (qualified by b_req)
//  b_be     in   DATA_W/8   byte enables for writes; bit i covers bits [8i+7:8i]
//  b_addr   in   ADDR_W     port-B word address
//  b_wdata  in   DATA_W     port-B write data
//  b_rdata  out  DATA_W     port-B read data
//  b_valid  out  1          one-cycle pulse: b_rdata valid (reads only)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): a_valid=b_valid=0, a_rdata=b_rdata=0, pipeline valids flushed, sweep counter=0.
//   ready=0 if CLEAR_INIT=1, else ready=1. RAM contents are not reset except by the sweep.
//  FSM (CLEAR_INIT=1): CLEAR -> RUN.
//   CLEAR: writes 0 to address cnt each cycle, cnt increments from 0; ready=0. At cnt=DEPTH-1, go to RUN next edge.
//   RUN: ready=1, stays until reset. Clear takes exactly DEPTH cycles after reset release.
//   Reset mid-sweep restarts at CLEAR, cnt=0. CLEAR_INIT=0: FSM is held in RUN.
//  Request accepted iff req=1 and ready=1 at the rising edge. Requests while ready=0 are dropped (no valid ever).
//  Reads: accepted at edge N -> valid pulses for one cycle after edge N+1 (OUT_REG=0) or edge N+2 (OUT_REG=1).
//   Fully pipelined: one request per port per cycle; each accepted read yields exactly one valid, in order.
//   rdata holds its last value while valid=0.
//  Writes: b_req&b_we at edge N writes the enabled bytes at edge N; disabled bytes keep old value; b_valid stays 0.
//   b_be=0 write is a no-op.
//  Collision, A read and B write to the same address at the same edge:
//   WRITE_MODE=0 -> a_rdata = pre-write word; WRITE_MODE=1 -> a_rdata = merged post-write word.
//   Read at edge N+1 of an address written at N always returns new data in both modes.
//  Addresses wrap naturally within ADDR_W; there is no out-of-range condition.
//  Ports A and B are independent; no port stalls the other.
// TESTING
//  T1 reset release, CLEAR_INIT=1, DEPTH=1024: ready rises after exactly 1024 cycles; A read 0x3FF -> 0x0000.
//  T2 B write 0xBEEF @5 be=11, then A read @5: OUT_REG=0 -> a_valid 1 cycle later with 0xBEEF; OUT_REG=1 -> 2 cycles later.
//  T3 B write 0x0012 @5 be=01 over 0xBEEF, then B read @5 -> b_rdata=0xBE12 and one b_valid pulse.
//  T4 @7=0x1111, same edge A read @7 + B write 0x2222: WRITE_MODE=0 -> 0x1111; WRITE_MODE=1 -> 0x2222.
//  T5 A reads @0..3 on 4 back-to-back cycles -> 4 consecutive a_valid pulses, data in address order.
//  T6 drop rst_n at cnt=300 for 1 cycle: ready stays 0 for a further 1024 cycles; a_req during clear -> no a_valid.

Source files
------------

// File: rtl/dual_port_stack_ram.sv
// dual_port_stack_ram
//   Synchronous dual-port word RAM for the stack processor.
//   Port A is a read-only instruction-fetch port; port B is a read/write data port
//   with byte enables. Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
//   On an A-read / B-write collision, A sees the old word (WRITE_MODE=0) or the merged
//   new word (WRITE_MODE=1). With CLEAR_INIT=1 every word is zeroed after reset before
//   any request is accepted.
//
// Ports
//   clka     clock, rising edge
//   rst_n    synchronous active-low reset
//   ready    requests are accepted while high (low during the clear sweep)
//   a_req    port-A read request
//   a_addr   port-A word address
//   a_rdata  port-A read data, held while a_valid is low
//   a_valid  one-cycle pulse per accepted A read
//   b_req    port-B request
//   b_we     port-B write (1) / read (0)
//   b_be     port-B byte enables for writes
//   b_addr   port-B word address
//   b_wdata  port-B write data
//   b_rdata  port-B read data, held while b_valid is low
//   b_valid  one-cycle pulse per accepted B read
module dual_port_stack_ram #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned OUT_REG    = 0,
   parameter int unsigned WRITE_MODE = 0,
   parameter int unsigned CLEAR_INIT = 1
) (
   input  logic                  clka,
   input  logic                  rst_n,
   output logic                  ready,
   input  logic                  a_req,
   input  logic [ADDR_W-1:0]     a_addr,
   output logic [DATA_W-1:0]     a_rdata,
   output logic                  a_valid,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [DATA_W/8-1:0]   b_be,
   input  logic [ADDR_W-1:0]     b_addr,
   input  logic [DATA_W-1:0]     b_wdata,
   output logic [DATA_W-1:0]     b_rdata,
   output logic                  b_valid
);

   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam int unsigned NumBytes = DATA_W / 8;

   typedef enum logic [0:0] {StClear, StRun} state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic                ready_q;

   logic [DATA_W-1:0]   mem [Depth];

   logic                a_acc;
   logic                b_wr;
   logic                b_rd;
   logic                clr_we;
   logic [DATA_W-1:0]   a_fwd;

   logic [DATA_W-1:0]   a_ram_q;
   logic [DATA_W-1:0]   b_ram_q;
   logic                a1_vld_q;
   logic                b1_vld_q;

   logic [DATA_W-1:0]   a_pre_data;
   logic [DATA_W-1:0]   b_pre_data;
   logic                a_pre_vld;
   logic                b_pre_vld;

   logic [DATA_W-1:0]   a_rdata_q;
   logic [DATA_W-1:0]   b_rdata_q;
   logic                a_valid_q;
   logic                b_valid_q;

   // Clear-sweep controller; ready is a registered FSM output.
   always_ff @(posedge clka) begin
      if (!rst_n) begin
         state_q <= (CLEAR_INIT != 0) ? StClear : StRun;
         cnt_q   <= '0;
         ready_q <= (CLEAR_INIT != 0) ? 1'b0 : 1'b1;
      end else begin
         unique case (state_q)
            StClear: begin
               cnt_q <= cnt_q + 1'b1;
               if (&cnt_q) begin
                  state_q <= StRun;
                  ready_q <= 1'b1;
               end
            end
            StRun: begin
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= StRun;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign a_acc  = rst_n & ready_q & a_req;
   assign b_wr   = rst_n & ready_q & b_req & b_we;
   assign b_rd   = rst_n & ready_q & b_req & ~b_we;
   assign clr_we = rst_n & (state_q == StClear);

   // Write-first bypass: A sees B's enabled bytes when both hit the same word this edge.
   always_comb begin
      a_fwd = mem[a_addr];
      if ((WRITE_MODE != 0) && b_wr && (b_addr == a_addr)) begin
         for (int i = 0; i < NumBytes; i++) begin
            if (b_be[i]) begin
               a_fwd[8*i +: 8] = b_wdata[8*i +: 8];
            end
         end
      end
   end

   // RAM array and read capture; no reset so the array maps onto block RAM.
   always_ff @(posedge clka) begin
      if (clr_we) begin
         mem[cnt_q] <= '0;
      end else if (b_wr) begin
         for (int i = 0; i < NumBytes; i++) begin
            if (b_be[i]) begin
               mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
            end
         end
      end
      a_ram_q <= a_fwd;
      b_ram_q <= mem[b_addr];
   end

   always_ff @(posedge clka) begin
      if (!rst_n) begin
         a1_vld_q <= 1'b0;
         b1_vld_q <= 1'b0;
      end else begin
         a1_vld_q <= a_acc;
         b1_vld_q <= b_rd;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] a2_data_q;
         logic [DATA_W-1:0] b2_data_q;
         logic              a2_vld_q;
         logic              b2_vld_q;

         always_ff @(posedge clka) begin
            if (!rst_n) begin
               a2_vld_q <= 1'b0;
               b2_vld_q <= 1'b0;
            end else begin
               a2_vld_q <= a1_vld_q;
               b2_vld_q <= b1_vld_q;
            end
            a2_data_q <= a_ram_q;
            b2_data_q <= b_ram_q;
         end

         assign a_pre_data = a2_data_q;
         assign b_pre_data = b2_data_q;
         assign a_pre_vld  = a2_vld_q;
         assign b_pre_vld  = b2_vld_q;
      end else begin : g_no_oreg
         assign a_pre_data = a_ram_q;
         assign b_pre_data = b_ram_q;
         assign a_pre_vld  = a1_vld_q;
         assign b_pre_vld  = b1_vld_q;
      end
   endgenerate

   // Output stage: data only updates alongside a valid so it holds between pulses.
   always_ff @(posedge clka) begin
      if (!rst_n) begin
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
      end else begin
         a_valid_q <= a_pre_vld;
         b_valid_q <= b_pre_vld;
         if (a_pre_vld) begin
            a_rdata_q <= a_pre_data;
         end
         if (b_pre_vld) begin
            b_rdata_q <= b_pre_data;
         end
      end
   end

   assign ready   = ready_q;
   assign a_rdata = a_rdata_q;
   assign a_valid = a_valid_q;
   assign b_rdata = b_rdata_q;
   assign b_valid = b_valid_q;

endmodule
